key_sw_io_dev: RTL and testbench
================================

Name: key_sw_io_dev

Overview:
Memory-mapped responder for the KEY and SW devices on the processor's data bus. It sits behind the memory-address decode, alongside the HEX/LEDR/LEDG output registers. It synchronizes the raw board inputs and debounces the switches. It holds the data registers plus sticky ready/overrun status per device, and raises an interrupt request when an enabled device has new data.

Parameters:
DBITS, 32, bus data/address width
ADDRKDATA, 32'hF0000010, KEY data register address (read-only)
ADDRSDATA, 32'hF0000014, SW data register address (read-only)
ADDRKCTRL, 32'hF0000110, KEY control/status register address
ADDRSCTRL, 32'hF0000114, SW control/status register address
DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a SW change is accepted (10 ms at 50 MHz)

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
KEY  input  4  raw push-buttons, active-low, asynchronous to clk
SW  input  10  raw slide switches, asynchronous to clk
addr  input  DBITS  bus address
rd_en  input  1  bus read strobe, one cycle per access
wr_en  input  1  bus write strobe, one cycle per access
wdata  input  DBITS  bus write data
rdata  output  DBITS  read data (combinational from addr)
sel  output  1  high when addr equals one of the four register addresses
intr  output  1  interrupt request

Behaviour:
- Reset (async, active-high) clears to 0: all synchronizer flops, kdata, sdata, SW candidate, debounce counter, both CTRL registers and intr.
- Input sync: KEY and SW each pass through 2 flops. The synced KEY is inverted so a pressed button reads 1.
- KDATA[3:0] loads the synced, inverted KEY every cycle; upper bits read 0. No debounce on KEY.
- SW debounce:
  - If synced SW differs from the candidate: candidate takes the new value and the counter goes to 0.
  - Otherwise the counter increments, saturating at DEBOUNCE_CYCLES-1.
  - When the counter equals DEBOUNCE_CYCLES-1 and candidate differs from sdata, sdata loads candidate.
  - Net effect: sdata updates DEBOUNCE_CYCLES+2 cycles after the raw change settles.
- SDATA[9:0] = sdata; upper bits read 0.
- CTRL layout (both devices): bit0 READY, bit2 OVERRUN, bit8 IE; all other bits read 0.
- Data-change event: the cycle in which the data register takes a new value.
  - On an event: READY <= 1.
  - If READY was already 1 and the same cycle is not a read of that device's DATA register: OVERRUN <= 1.
- Read of DATA (rd_en && addr==DATA address) clears that device's READY at the clock edge.
  - A read and an event in the same cycle leave READY=1 and do not set OVERRUN.
- Write to CTRL (wr_en && addr==CTRL address):
  - IE <= wdata[8].
  - OVERRUN is cleared when wdata[2]==0; writing 1 leaves it unchanged.
  - READY is unaffected by writes.
  - If a write clearing OVERRUN and an overrun-setting event coincide, the event wins (OVERRUN=1).
- Writes to DATA addresses are ignored.
- Reads of CTRL have no side effects.
- rdata: the selected register value when sel=1, else 0. It is independent of rd_en and has zero latency.
- intr is registered: intr <= (KREADY&KIE) | (SREADY&SIE), so it follows the status by 1 cycle.
- After reset, SW held non-zero produces one SW event after the debounce interval. Bench and software must tolerate this.
- rd_en and wr_en both asserted in the same cycle: each is applied as specified independently.

Test Plan:
- Reset with KEY=4'hF, SW=0 → all outputs 0. Read ADDRKDATA → rdata=0, sel=1. Read addr 32'hF0000018 → sel=0, rdata=0.
- Drive KEY=4'b1110 → 3 cycles later KDATA=1 and KCTRL=32'h1. Read KDATA → the next cycle KCTRL=0.
- With DEBOUNCE_CYCLES=4, set SW=10'h2A5 and glitch SW back for 2 cycles mid-way → SDATA stays 0 until SW is stable for 4+2 cycles, then SDATA=32'h2A5 and SCTRL=1.
- Two KEY changes with no read in between → KCTRL=32'h5. Write KCTRL with wdata=0 → KCTRL=32'h1. Read KDATA in the same cycle as a third change → KCTRL=32'h1 with OVERRUN=0.
- Write KCTRL with wdata=32'h100 while KREADY=1 → intr=1 one cycle later. Read KDATA → intr=0 one cycle after READY clears. Write SCTRL with wdata=32'hFFFF → SCTRL shows IE only, READY unchanged.
- Assert reset asynchronously mid-debounce, between clk edges → all registers clear immediately. After release, debouncing restarts from 0.

Source files
------------

// File: rtl/key_sw_io_dev.sv
// KEY/SW memory-mapped input device: synchronizers, switch debounce, data and
// sticky READY/OVERRUN/IE status per device, registered interrupt request.
module key_sw_io_dev #(
  parameter int unsigned      DBITS           = 32,
  parameter logic [DBITS-1:0] ADDRKDATA       = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDRSDATA       = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDRKCTRL       = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDRSCTRL       = 32'hF0000114,
  parameter int unsigned      DEBOUNCE_CYCLES = 500000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       KEY,
  input  logic [9:0]       SW,
  input  logic [DBITS-1:0] addr,
  input  logic             rd_en,
  input  logic             wr_en,
  input  logic [DBITS-1:0] wdata,
  output logic [DBITS-1:0] rdata,
  output logic             sel,
  output logic             intr
);

  localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  // KEY is inverted on entry so the synchronizer's reset value means "not pressed".
  logic [3:0]      key_s1_q, key_s2_q, kdata_q;
  logic [9:0]      sw_s1_q, sw_s2_q, cand_q, sdata_q;
  logic [9:0]      cand_d, sdata_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            krdy_q, kovr_q, kie_q, srdy_q, sovr_q, sie_q, intr_q;
  logic            krdy_d, kovr_d, kie_d, srdy_d, sovr_d, sie_d;
  logic            k_evt, s_evt, k_rd, s_rd, k_wr, s_wr;

  assign k_rd  = rd_en && (addr == ADDRKDATA);
  assign s_rd  = rd_en && (addr == ADDRSDATA);
  assign k_wr  = wr_en && (addr == ADDRKCTRL);
  assign s_wr  = wr_en && (addr == ADDRSCTRL);
  assign k_evt = (key_s2_q != kdata_q);

  always_comb begin
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    sdata_d = sdata_q;
    if (sw_s2_q != cand_q) begin
      cand_d = sw_s2_q;
      cnt_d  = '0;
    end else if (cnt_q != CntMax) begin
      cnt_d = cnt_q + 1'b1;
    end
    if (cnt_q == CntMax && cand_q != sdata_q) begin
      sdata_d = cand_q;
    end
  end

  assign s_evt = (sdata_d != sdata_q);

  // An event beats a same-cycle read (READY stays) and a same-cycle OVERRUN clear.
  always_comb begin
    krdy_d = k_evt ? 1'b1 : (k_rd ? 1'b0 : krdy_q);
    srdy_d = s_evt ? 1'b1 : (s_rd ? 1'b0 : srdy_q);
    kovr_d = kovr_q;
    sovr_d = sovr_q;
    kie_d  = k_wr ? wdata[8] : kie_q;
    sie_d  = s_wr ? wdata[8] : sie_q;
    if (k_wr && !wdata[2]) kovr_d = 1'b0;
    if (s_wr && !wdata[2]) sovr_d = 1'b0;
    if (k_evt && krdy_q && !k_rd) kovr_d = 1'b1;
    if (s_evt && srdy_q && !s_rd) sovr_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_s1_q <= '0;
      key_s2_q <= '0;
      kdata_q  <= '0;
      sw_s1_q  <= '0;
      sw_s2_q  <= '0;
      cand_q   <= '0;
      cnt_q    <= '0;
      sdata_q  <= '0;
      krdy_q   <= 1'b0;
      kovr_q   <= 1'b0;
      kie_q    <= 1'b0;
      srdy_q   <= 1'b0;
      sovr_q   <= 1'b0;
      sie_q    <= 1'b0;
      intr_q   <= 1'b0;
    end else begin
      key_s1_q <= ~KEY;
      key_s2_q <= key_s1_q;
      kdata_q  <= key_s2_q;
      sw_s1_q  <= SW;
      sw_s2_q  <= sw_s1_q;
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      sdata_q  <= sdata_d;
      krdy_q   <= krdy_d;
      kovr_q   <= kovr_d;
      kie_q    <= kie_d;
      srdy_q   <= srdy_d;
      sovr_q   <= sovr_d;
      sie_q    <= sie_d;
      intr_q   <= (krdy_q & kie_q) | (srdy_q & sie_q);
    end
  end

  assign intr = intr_q;

  always_comb begin
    rdata = '0;
    sel   = 1'b1;
    if (addr == ADDRKDATA) begin
      rdata[3:0] = kdata_q;
    end else if (addr == ADDRSDATA) begin
      rdata[9:0] = sdata_q;
    end else if (addr == ADDRKCTRL) begin
      rdata[0] = krdy_q;
      rdata[2] = kovr_q;
      rdata[8] = kie_q;
    end else if (addr == ADDRSCTRL) begin
      rdata[0] = srdy_q;
      rdata[2] = sovr_q;
      rdata[8] = sie_q;
    end else begin
      sel = 1'b0;
    end
  end

endmodule

// File: tb/tb_key_sw_io_dev.sv
// Directed bench for key_sw_io_dev: a per-cycle bus/KEY vector table plus
// hand-written sequences for switch debounce and asynchronous reset.
module tb_key_sw_io_dev;

  localparam int unsigned DB = 4;
  localparam logic [31:0] KD  = 32'hF0000010;
  localparam logic [31:0] SD  = 32'hF0000014;
  localparam logic [31:0] KC  = 32'hF0000110;
  localparam logic [31:0] SC  = 32'hF0000114;
  localparam logic [31:0] BAD = 32'hF0000018;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  KEY;
  logic [9:0]  SW;
  logic [31:0] addr, wdata, rdata;
  logic        rd_en, wr_en, sel, intr;

  int total = 0;
  int bad   = 0;

  key_sw_io_dev #(
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .KEY   (KEY),
    .SW    (SW),
    .addr  (addr),
    .rd_en (rd_en),
    .wr_en (wr_en),
    .wdata (wdata),
    .rdata (rdata),
    .sel   (sel),
    .intr  (intr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  key;
    logic [31:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_sel;
    logic        exp_intr;
  } vec_t;

  vec_t vecs[33];

  function automatic vec_t mk(logic [3:0] k, logic [31:0] a, logic r, logic w,
                              logic [31:0] wd, logic [31:0] er, logic es, logic ei);
    vec_t v;
    v.key = k; v.addr = a; v.rd = r; v.wr = w; v.wdata = wd;
    v.exp_rdata = er; v.exp_sel = es; v.exp_intr = ei;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [31:0] a, input logic r, input logic w, input logic [31:0] wd);
    addr = a; rd_en = r; wr_en = w; wdata = wd;
  endtask

  // Counts edges from now until SDATA equals want; checks it lands in the debounce window.
  task automatic wait_sdata(input string name, input logic [31:0] want);
    int  n;
    bit  got;
    n = 0;
    got = 1'b0;
    bus(SD, 1'b0, 1'b0, '0);
    while (!got && n < 30) begin
      tick();
      n++;
      if (rdata == want) got = 1'b1;
      else chk({name, "_early_hold"}, rdata, 32'h0);
    end
    total++;
    if (!got || n < DB + 2 || n > DB + 3) begin
      bad++;
      $display("FAIL %s: got edges=%0d seen=%0d want edges %0d..%0d", name, n, got, DB + 2,
               DB + 3);
    end
  endtask

  initial begin
    vecs[0]  = mk(4'hF, KD, 0, 0, 0, 32'h0, 1, 0);
    vecs[1]  = mk(4'hE, KC, 0, 0, 0, 32'h0, 1, 0);
    vecs[2]  = mk(4'hE, KC, 0, 0, 0, 32'h0, 1, 0);
    vecs[3]  = mk(4'hE, KC, 0, 0, 0, 32'h0, 1, 0);
    vecs[4]  = mk(4'hE, KD, 0, 0, 0, 32'h1, 1, 0);
    vecs[5]  = mk(4'hE, KC, 0, 0, 0, 32'h1, 1, 0);
    vecs[6]  = mk(4'hE, KD, 1, 0, 0, 32'h1, 1, 0);
    vecs[7]  = mk(4'hE, KC, 0, 0, 0, 32'h0, 1, 0);
    vecs[8]  = mk(4'hC, KC, 0, 0, 0, 32'h0, 1, 0);
    vecs[9]  = mk(4'hC, KC, 0, 0, 0, 32'h0, 1, 0);
    vecs[10] = mk(4'hC, KC, 0, 0, 0, 32'h0, 1, 0);
    vecs[11] = mk(4'h8, KC, 0, 0, 0, 32'h1, 1, 0);
    vecs[12] = mk(4'h8, KC, 0, 0, 0, 32'h1, 1, 0);
    vecs[13] = mk(4'h8, KC, 0, 0, 0, 32'h1, 1, 0);
    vecs[14] = mk(4'h8, KC, 0, 0, 0, 32'h5, 1, 0);
    vecs[15] = mk(4'h8, KC, 0, 1, 0, 32'h5, 1, 0);
    vecs[16] = mk(4'h8, KC, 0, 0, 0, 32'h1, 1, 0);
    vecs[17] = mk(4'h0, KC, 0, 0, 0, 32'h1, 1, 0);
    vecs[18] = mk(4'h0, KC, 0, 0, 0, 32'h1, 1, 0);
    vecs[19] = mk(4'h0, KD, 1, 0, 0, 32'h7, 1, 0);
    vecs[20] = mk(4'h0, KC, 0, 0, 0, 32'h1, 1, 0);
    vecs[21] = mk(4'h0, KD, 0, 0, 0, 32'hF, 1, 0);
    vecs[22] = mk(4'h0, KC, 0, 1, 32'h100, 32'h1, 1, 0);
    vecs[23] = mk(4'h0, KC, 0, 0, 0, 32'h101, 1, 0);
    vecs[24] = mk(4'h0, KC, 0, 0, 0, 32'h101, 1, 1);
    vecs[25] = mk(4'h0, KD, 1, 0, 0, 32'hF, 1, 1);
    vecs[26] = mk(4'h0, KC, 0, 0, 0, 32'h100, 1, 1);
    vecs[27] = mk(4'h0, KC, 0, 0, 0, 32'h100, 1, 0);
    vecs[28] = mk(4'h0, SC, 0, 1, 32'hFFFF, 32'h0, 1, 0);
    vecs[29] = mk(4'h0, SC, 0, 0, 0, 32'h100, 1, 0);
    vecs[30] = mk(4'h0, SD, 0, 1, 32'hFFFF, 32'h0, 1, 0);
    vecs[31] = mk(4'h0, SD, 0, 0, 0, 32'h0, 1, 0);
    vecs[32] = mk(4'h0, BAD, 1, 1, 32'hFFFF, 32'h0, 0, 0);

    reset = 1'b1;
    KEY = 4'hF;
    SW = '0;
    bus(KD, 1'b0, 1'b0, '0);
    repeat (3) tick();
    chk("rst_kdata", rdata, 32'h0);
    chk("rst_kdata_sel", {31'b0, sel}, 32'h1);
    chk("rst_intr", {31'b0, intr}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    repeat (6) tick();

    foreach (vecs[i]) begin
      KEY = vecs[i].key;
      bus(vecs[i].addr, vecs[i].rd, vecs[i].wr, vecs[i].wdata);
      #1;
      chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      chk($sformatf("vec%0d_sel", i), {31'b0, sel}, {31'b0, vecs[i].exp_sel});
      chk($sformatf("vec%0d_intr", i), {31'b0, intr}, {31'b0, vecs[i].exp_intr});
      tick();
    end
    bus(SD, 1'b0, 1'b0, '0);

    // Switch bounce: a short pulse must not be accepted.
    SW = 10'h2A5;
    repeat (2) tick();
    SW = 10'h000;
    repeat (2) tick();
    chk("sw_glitch_hold", rdata, 32'h0);
    SW = 10'h2A5;
    wait_sdata("sw_debounce", 32'h2A5);
    bus(SC, 1'b0, 1'b0, '0);
    #1;
    chk("sctrl_ready", rdata, 32'h101);
    chk("sw_intr_lag", {31'b0, intr}, 32'h0);
    tick();
    chk("sw_intr", {31'b0, intr}, 32'h1);
    bus(SD, 1'b1, 1'b0, '0);
    tick();
    bus(SC, 1'b0, 1'b0, '0);
    #1;
    chk("sctrl_after_read", rdata, 32'h100);

    // Asynchronous reset between clock edges, mid-debounce.
    KEY = 4'hF;
    SW = 10'h155;
    repeat (4) tick();
    #3;
    reset = 1'b1;
    #1;
    chk("async_sctrl", rdata, 32'h0);
    chk("async_intr", {31'b0, intr}, 32'h0);
    addr = KC;
    #1;
    chk("async_kctrl", rdata, 32'h0);
    addr = SD;
    #1;
    chk("async_sdata", rdata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    wait_sdata("sw_after_reset", 32'h155);
    bus(SC, 1'b0, 1'b0, '0);
    #1;
    chk("sctrl_after_reset", rdata, 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
